// File: rtl/mac_accum.sv
// mac_accum -- streaming multiply-accumulate back end.
//
// Sums TAPS consecutive signed 32-bit products from the partial-product
// combiner into one frame result. The result is arithmetic-shifted right by
// SHIFT and reduced to OUT_W bits. It is then offered on a valid/ready port.
// The frame counter restarts on every final accept, so the accumulator never
// needs clearing between frames.
//
// Optional build macro:
//   MAC_ACCUM_SAT_EN  when defined, width reduction saturates to the OUT_W
//                     signed range. When undefined, the upper bits are
//                     truncated (wrap). ovf_o flags the overflow either way.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   prod_i       signed product from the combiner
//   prod_valid   prod_i valid this cycle
//   prod_ready   block accepts prod_i this cycle (combinational)
//   clear_i      synchronous abort of the partial frame; also clears ovf_o
//   out_data     signed, scaled and reduced frame sum
//   out_valid    out_data valid
//   out_ready    consumer accepts out_data
//   ovf_o        sticky overflow flag (cleared by clear_i or reset)
//   cnt_o        products accepted so far in the current frame

module mac_accum #(
    parameter int TAPS  = 8,
    parameter int ACC_W = 40,
    parameter int SHIFT = 0,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      prod_i,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear_i,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf_o,
    output logic [7:0]       cnt_o
);

    typedef enum logic {
        ACC  = 1'b0,  // no result pending
        HOLD = 1'b1   // result presented, waiting for out_ready
    } state_t;

    localparam logic [7:0] LAST = 8'(TAPS - 1);

    state_t                   state, state_next;
    logic signed [ACC_W-1:0]  acc, acc_next;
    logic [7:0]               cnt, cnt_next;
    logic [OUT_W-1:0]         out_data_next;
    logic                     ovf_next;

    logic                     accept;
    logic                     last;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [ACC_W-OUT_W:0]     upper;      // discarded bits plus the new sign bit
    logic                     wrap_ovf;
    logic [OUT_W-1:0]         reduced;

    // A pending result can be released in the same cycle that a new final
    // accept overwrites it, so input is accepted whenever out_ready is high.
    assign prod_ready = (state == ACC) | out_ready;
    assign out_valid  = (state == HOLD);
    assign cnt_o      = cnt;

    assign accept   = prod_valid & prod_ready;
    assign last     = (cnt == LAST);
    assign prod_ext = ACC_W'($signed(prod_i));

    // cnt==0 marks the first product of a frame, so the stale sum is ignored.
    assign acc_sum  = ((cnt == 8'd0) ? '0 : acc) + prod_ext;
    assign shifted  = acc_sum >>> SHIFT;

    // The result fits in OUT_W bits only if every bit from OUT_W-1 upward
    // is a copy of the sign.
    assign upper    = shifted[ACC_W-1:OUT_W-1];
    assign wrap_ovf = !((&upper) || !(|upper));

`ifdef MAC_ACCUM_SAT_EN
    assign reduced = !wrap_ovf        ? shifted[OUT_W-1:0] :
                     shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                        {1'b0, {(OUT_W-1){1'b1}}};
`else
    assign reduced = shifted[OUT_W-1:0];
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves one unassigned would otherwise infer a latch.
        state_next    = state;
        acc_next      = acc;
        cnt_next      = cnt;
        out_data_next = out_data;
        ovf_next      = ovf_o;

        if (state == HOLD && out_ready) begin
            state_next = ACC;
        end

        // A clear discards any product taken in the same cycle. A pending
        // result is still delivered.
        if (clear_i) begin
            cnt_next = 8'd0;
            ovf_next = 1'b0;
        end else if (accept) begin
            if (last) begin
                cnt_next      = 8'd0;
                out_data_next = reduced;
                state_next    = HOLD;
                if (wrap_ovf) begin
                    ovf_next = 1'b1;
                end
            end else begin
                acc_next = acc_sum;
                cnt_next = cnt + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACC;
            acc      <= '0;
            cnt      <= 8'd0;
            out_data <= '0;
            ovf_o    <= 1'b0;
        end else begin
            state    <= state_next;
            acc      <= acc_next;
            cnt      <= cnt_next;
            out_data <= out_data_next;
            ovf_o    <= ovf_next;
        end
    end

endmodule

// File: tb/tb_mac_accum.sv
// tb_mac_accum -- self-checking bench for mac_accum.
//
// Two instances share all inputs: u_dut uses the defaults (TAPS=8, SHIFT=0)
// and u_dut_s3 uses SHIFT=3. The stimulus process pushes the hand-computed
// result of each frame into a scoreboard queue. A monitor pops and compares
// on every output handshake. Timing properties are checked inline. These
// are latency, backpressure hold, throughput, clear, and asynchronous reset.
// Inputs change 1 time unit after a rising edge, and outputs are sampled on
// the falling edge.

module tb_mac_accum;

    logic        clk;
    logic        rst_n;
    logic [31:0] prod_i;
    logic        prod_valid;
    logic        clear_i;
    logic        out_ready;

    logic        prod_ready, prod_ready3;
    logic [31:0] out_data, out_data3;
    logic        out_valid, out_valid3;
    logic        ovf_o, ovf3;
    logic [7:0]  cnt_o, cnt3;

    typedef struct {
        logic [31:0] d0;    // expected out_data, SHIFT=0
        logic        ovf0;  // expected ovf_o,    SHIFT=0
        logic [31:0] d3;    // expected out_data, SHIFT=3
    } exp_t;

    exp_t sb[$];
    int   hs_q[$];
    int   cyc;
    int   n_cmp;
    int   n_fail;

    mac_accum u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_i     (prod_i),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear_i    (clear_i),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf_o      (ovf_o),
        .cnt_o      (cnt_o)
    );

    mac_accum #(.SHIFT(3)) u_dut_s3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_i     (prod_i),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready3),
        .clear_i    (clear_i),
        .out_data   (out_data3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready),
        .ovf_o      (ovf3),
        .cnt_o      (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_out(input logic [31:0] d0, input logic ovf0, input logic [31:0] d3);
        exp_t e;
        e.d0   = d0;
        e.ovf0 = ovf0;
        e.d3   = d3;
        sb.push_back(e);
    endtask

    // Present one product and return one time unit after the edge that
    // accepted it. stalls counts cycles in which prod_ready was low.
    task automatic send(input logic [31:0] v, output int stalls);
        bit done;
        done       = 1'b0;
        stalls     = 0;
        prod_i     = v;
        prod_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (prod_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 50) begin
                    check("accept_timeout", 64'(stalls), 64'd0);
                    done = 1'b1;
                end
            end
        end
        #1;
        prod_valid = 1'b0;
    endtask

    task automatic send_n(input logic [31:0] v, input int n, output int stalls);
        int s;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            send(v, s);
            stalls += s;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: compares every result on its handshake cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            hs_q.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_output", {32'd0, out_data}, 64'hDEAD_0000_0000_0000);
            end else begin
                e = sb.pop_front();
                check("out_data",  64'(out_data), 64'(e.d0));
                check("ovf_o",     64'(ovf_o), 64'(e.ovf0));
                check("s3_data",   {31'd0, out_valid3, out_data3}, {31'd0, 1'b1, e.d3});
                check("s3_ovf",    64'(ovf3), 64'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int st;
        int st_total;

        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        prod_i     = '0;
        prod_valid = 1'b0;
        clear_i    = 1'b0;
        out_ready  = 1'b1;

        // Reset state.
        idle(2);
        check("reset_state", {out_valid, prod_ready, ovf_o, cnt_o, out_data},
              {1'b0, 1'b1, 1'b0, 8'd0, 32'd0});
        rst_n = 1'b1;
        idle(1);

        // Products 1..8 back-to-back: one result of 36, one cycle after the
        // final accept, lasting a single cycle.
        expect_out(32'd36, 1'b0, 32'd4);
        for (int i = 1; i <= 7; i++) send(32'(i), st);
        check("valid_before_final", 64'(out_valid), 64'd0);
        send(32'd8, st);
        check("latency_1", 64'(out_valid), 64'd1);
        idle(1);
        check("single_pulse", 64'(out_valid), 64'd0);

        // Backpressure: result 24 held stable for 5 cycles with prod_ready low.
        out_ready = 1'b0;
        expect_out(32'd24, 1'b0, 32'd3);
        send_n(32'd3, 8, st);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_stable", {out_valid, prod_ready, prod_ready3, out_data},
                  {1'b1, 1'b0, 1'b0, 32'd24});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(1);
        check("released", {out_valid, prod_ready}, {1'b1 ^ 1'b1, 1'b1});

        // Throughput: 16 ones -> two results of 8, 8 cycles apart, no stalls.
        expect_out(32'd8, 1'b0, 32'd1);
        expect_out(32'd8, 1'b0, 32'd1);
        send_n(32'd1, 16, st_total);
        idle(2);
        check("no_stall", 64'(st_total), 64'd0);
        if (hs_q.size() >= 2)
            check("result_spacing", 64'(hs_q[hs_q.size()-1] - hs_q[hs_q.size()-2]), 64'd8);
        else
            check("result_count", 64'(hs_q.size()), 64'd2);

        // Overflow: eight products of 0x80000000 sum to -2^34.
`ifdef MAC_ACCUM_SAT_EN
        expect_out(32'h8000_0000, 1'b1, 32'h8000_0000);
`else
        expect_out(32'h0000_0000, 1'b1, 32'h8000_0000);
`endif
        send_n(32'h8000_0000, 8, st);
        idle(3);
        check("ovf_sticky", 64'(ovf_o), 64'd1);

        // Clear: 100, 200, 300, then a cleared 999, then eight 5s -> 40.
        // The clear also drops the sticky overflow.
        expect_out(32'd40, 1'b0, 32'd5);
        send(32'd100, st);
        send(32'd200, st);
        send(32'd300, st);
        check("cnt_before_clear", 64'(cnt_o), 64'd3);
        clear_i = 1'b1;
        send(32'd999, st);
        clear_i = 1'b0;
        check("cnt_after_clear", {ovf_o, cnt_o}, {1'b0, 8'd0});
        send_n(32'd5, 8, st);
        idle(2);

        // Asynchronous reset mid-frame, between clock edges.
        send_n(32'd7, 4, st);
        check("cnt_mid_frame", 64'(cnt_o), 64'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {out_valid, ovf_o, cnt_o, cnt3, out_data},
              {1'b0, 1'b0, 8'd0, 8'd0, 32'd0});
        #1;
        rst_n = 1'b1;
        idle(1);
        expect_out(32'd16, 1'b0, 32'd2);
        send_n(32'd2, 8, st);
        idle(3);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
